// File: rtl/dsc_pkg.sv
// Shared definitions for the stochastic-number datapath: clog2 helper, SNG state
// enum and the default frame geometry.
package dsc_pkg;

  function automatic int unsigned CLOG2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'(1) << k) < 64'(v)) r = k + 1;
    end
    return r;
  endfunction

  typedef enum logic [0:0] {
    SNG_IDLE = 1'b0,
    SNG_RUN  = 1'b1
  } sng_state_e;

  localparam int unsigned SNG_WIDTH = 8;
  localparam int unsigned SNG_LANES = 1;
  localparam int unsigned PHASE_W   = SNG_WIDTH - CLOG2(SNG_LANES);
  localparam int unsigned ONES_W    = CLOG2(SNG_LANES + 1);

endpackage

// File: rtl/popcount.sv
// Combinational ones counter over an N-bit vector.
module popcount
  import dsc_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic [N-1:0]             bits,
  output logic [CLOG2(N+1)-1:0]    ones_c
);

  localparam int unsigned W = CLOG2(N + 1);

  always_comb begin
    ones_c = '0;
    for (int i = 0; i < N; i++) begin
      ones_c = ones_c + W'(bits[i]);
    end
  end

endmodule

// File: rtl/sng_frame_gen.sv
// Exact-weight stochastic bitstream frame generator, LANES bits per beat.
// Define SNG_LD_EN for bit-reversed (van der Corput) ordering instead of a ramp.
module sng_frame_gen
  import dsc_pkg::*;
#(
  parameter int unsigned WIDTH = SNG_WIDTH,
  parameter int unsigned LANES = SNG_LANES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_value,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [LANES-1:0]            out_bits,
  output logic [CLOG2(LANES+1)-1:0]   out_ones,
  output logic                        out_last
);

  localparam int unsigned LANE_W   = CLOG2(LANES);
  localparam int unsigned PH_W     = WIDTH - LANE_W;
  localparam int unsigned PH_REG_W = (PH_W == 0) ? 1 : PH_W;
  localparam int unsigned ON_W     = CLOG2(LANES + 1);
  localparam int unsigned PH_MAX   = (1 << PH_W) - 1;

  sng_state_e              state_q, state_d;
  logic [WIDTH-1:0]        val_q, val_d;
  logic [PH_REG_W-1:0]     phase_q, phase_d;
  logic                    accept, advance, run_d, last_d;
  logic [LANES-1:0]        bits_d;
  logic [ON_W-1:0]         ones_d;

  // Lane i compares the frame value against its (optionally bit-reversed) slot index.
  function automatic logic [LANES-1:0] lane_bits(input logic [WIDTH-1:0]    val,
                                                 input logic [PH_REG_W-1:0] phase);
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] src;
    lane_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = (WIDTH'(phase) << LANE_W) | WIDTH'(i);
      src = idx;
`ifdef SNG_LD_EN
      for (int b = 0; b < WIDTH; b++) src[b] = idx[WIDTH-1-b];
`endif
      lane_bits[i] = (val > src);
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SNG_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SNG_IDLE: if (in_valid) state_d = SNG_RUN;
      SNG_RUN:  if (advance && out_last && !in_valid) state_d = SNG_IDLE;
      default:  state_d = SNG_IDLE;
    endcase
  end

  // in_ready is deliberately combinational from out_ready so frames chain with no bubble.
  always_comb begin
    in_ready = (state_q == SNG_IDLE) || ((state_q == SNG_RUN) && out_last && out_ready);
  end

  always_comb begin
    advance = out_valid && out_ready;
    accept  = in_valid && in_ready;
    val_d   = accept ? in_value : val_q;
    phase_d = phase_q;
    if (accept)       phase_d = '0;
    else if (advance) phase_d = phase_q + PH_REG_W'(1);
    run_d  = (state_d == SNG_RUN);
    last_d = run_d && (phase_d == PH_REG_W'(PH_MAX));
    bits_d = run_d ? lane_bits(val_d, phase_d) : '0;
  end

  popcount #(.N(LANES)) u_popcount (
    .bits   (bits_d),
    .ones_c (ones_d)
  );

  // Outputs are precomputed from next-state values so the beat is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q     <= '0;
      phase_q   <= '0;
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_ones  <= '0;
      out_last  <= 1'b0;
    end else begin
      val_q     <= val_d;
      phase_q   <= phase_d;
      out_valid <= run_d;
      out_bits  <= bits_d;
      out_ones  <= ones_d;
      out_last  <= last_d;
    end
  end

endmodule
